sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one half-precision square-root unit (sqrt2) among N_REQ requesters.
- Accepts operands and grants one requester at a time. Drives sqrt2's ENABLE and its bidirectional IO_DATA bus without contention.
- Waits for RESULT, captures the result word and flags into a single-entry response register, then pulses ENABLE low so the unit clears before the next operation.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of RSP_ID; must satisfy 2**ID_W >= N_REQ
TIMEOUT, 20, maximum WAIT cycles before the operation is aborted

Ports:
CLK  input  1  clock, all logic on rising edge
RESET  input  1  asynchronous, active-high reset
REQ  input  N_REQ  per-requester request level; held until that requester's ACK bit pulses
REQ_DATA  input  16*N_REQ  operand of requester i in bits [16i+15:16i]
REQ_ACK  output  N_REQ  one-hot, one-cycle pulse: operand of that requester accepted
RSP_VALID  output  1  response register full
RSP_READY  input  1  consumer accepts the response when RSP_VALID=1
RSP_ID  output  ID_W  index of the requester the response belongs to
RSP_DATA  output  16  result word
RSP_NAN  output  1  captured IS_NAN
RSP_PINF  output  1  captured IS_PINF
RSP_NINF  output  1  captured IS_NINF
RSP_ERR  output  1  timeout abort
SQ_ENABLE  output  1  to sqrt2 ENABLE
SQ_IO_DATA  inout  16  to sqrt2 IO_DATA
SQ_RESULT  input  1  from sqrt2 RESULT
SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF  input  1 each  from sqrt2 flags

Behaviour:
- Reset (async, any state):
  - State goes to IDLE. SQ_ENABLE=0, SQ_IO_DATA released (Z), REQ_ACK=0.
  - RSP_* all 0. Round-robin pointer = 0. Timeout counter = 0.
- States are IDLE, ISSUE, WAIT, GAP. All outputs are registered except the SQ_IO_DATA tristate enable, which is decoded from state==ISSUE.
- IDLE:
  - Entry condition for a grant: any REQ bit set and (RSP_VALID=0, or RSP_VALID&RSP_READY in this cycle).
  - Winner is the first set REQ bit at or after the pointer, wrapping modulo N_REQ.
  - Latch the winner's operand and index, set the pointer to winner+1 (wrapping), go to ISSUE.
  - No request means stay in IDLE.
- ISSUE (exactly 1 cycle):
  - SQ_ENABLE=1, SQ_IO_DATA driven with the latched operand, REQ_ACK[winner]=1.
  - sqrt2 samples the operand at the closing edge. Go to WAIT.
- WAIT:
  - SQ_ENABLE=1, SQ_IO_DATA is Z. sqrt2 drives the bus starting one edge later.
  - The timeout counter increments every WAIT cycle.
  - SQ_RESULT=1 sampled at an edge:
    - RSP_DATA<=SQ_IO_DATA, and the flags are copied from SQ_IS_*.
    - RSP_ID<=latched index, RSP_ERR<=0, RSP_VALID<=1.
    - Go to GAP.
  - Counter reaches TIMEOUT first:
    - RSP_DATA<=16'h7E00, RSP_NAN<=1, RSP_ERR<=1, RSP_VALID<=1.
    - Go to GAP.
- GAP (exactly 1 cycle): SQ_ENABLE=0, which clears sqrt2. Timeout counter is cleared. Go to IDLE.
- Response register:
  - RSP_VALID clears on the edge where RSP_VALID&RSP_READY.
  - A new capture and a clear never coincide, because at least 3 cycles separate issue from capture.
- Latency, counted from the first ISSUE cycle to the first cycle RSP_VALID=1:
  - Normal operand: 13 cycles.
  - Special operand (NaN, +inf, -0): 3 cycles.
  - Back-to-back throughput with RSP_READY=1: normal operands 15 cycles per operation (ISSUE + 12 WAIT + GAP + IDLE).
- Bus safety:
  - The controller drives SQ_IO_DATA only during ISSUE, while sqrt2's internal counter is <2.
  - It is never driven during WAIT or GAP.
- REQ deassertion:
  - A requester dropping REQ before its ACK simply loses arbitration; no ACK is given.
  - Once REQ_ACK has pulsed, the operation completes regardless of REQ.
- Simultaneous requests: exactly one ACK per grant. Starvation-free; any held REQ is granted within N_REQ grants.

Test Plan:
- Single requester 0, REQ_DATA=16'h4400 (4.0) -> one ACK[0] pulse; RSP_VALID 13 cycles after ISSUE; RSP_DATA=16'h4000, RSP_ID=0, all flags 0, RSP_ERR=0.
- Requester 1 sends 16'h7C00 (+inf) -> RSP_VALID after 3 cycles; RSP_DATA=16'h7C00, RSP_PINF=1. Requester 2 sends 16'hBC00 (-1.0) -> RSP_DATA=16'hFE00, RSP_NAN=1.
- All 4 REQ held with RSP_READY=1 -> grant order 0,1,2,3,0; consecutive ACKs 15 cycles apart for normal operands; RSP_ID follows the same order.
- RSP_READY=0 for 40 cycles after the first response -> no further ACK; RSP_DATA held stable; the next grant occurs in the IDLE cycle where RSP_READY=1.
- SQ_RESULT tied 0 (stub unit) -> after TIMEOUT=20 WAIT cycles, RSP_ERR=1, RSP_DATA=16'h7E00, RSP_NAN=1; SQ_ENABLE low for 1 cycle.
- RESET asserted mid-WAIT -> SQ_ENABLE=0 and SQ_IO_DATA=Z immediately; RSP_VALID=0. After release, the next grant goes to requester 0. The bench bus monitor reports no X on SQ_IO_DATA during any run.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter and sequencer sharing one half-precision square-root unit among
// N_REQ requesters, with a single-entry response register and a WAIT timeout.
module sqrt_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned TIMEOUT = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [16*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      req_ack,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [15:0]           rsp_data,
   output logic                  rsp_nan,
   output logic                  rsp_pinf,
   output logic                  rsp_ninf,
   output logic                  rsp_err,
   output logic                  sq_enable,
   inout  wire  [15:0]           sq_io_data,
   input  logic                  sq_result,
   input  logic                  sq_is_nan,
   input  logic                  sq_is_pinf,
   input  logic                  sq_is_ninf
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

   state_e           state;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  id_q;
   logic [15:0]      op_q;
   logic [CNT_W-1:0] tmo_cnt;

   logic             win_found;
   logic [ID_W-1:0]  win_idx;
   logic [ID_W:0]    cand;
   logic [15:0]      win_op;
   logic [ID_W-1:0]  nxt_ptr;
   logic             grant_ok;

   // First set request at or after the pointer, wrapping modulo N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!win_found && req[cand[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      win_op   = req_data[16*win_idx +: 16];
      nxt_ptr  = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      grant_ok = win_found && (!rsp_valid || rsp_ready);
   end

   // Only ISSUE drives the shared bus; the unit owns it from the following edge on.
   assign sq_io_data = (state == StIssue) ? op_q : 16'bz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         ptr       <= '0;
         id_q      <= '0;
         op_q      <= '0;
         tmo_cnt   <= '0;
         req_ack   <= '0;
         sq_enable <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_nan   <= 1'b0;
         rsp_pinf  <= 1'b0;
         rsp_ninf  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         req_ack <= '0;
         if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         unique case (state)
            StIdle: begin
               if (grant_ok) begin
                  op_q      <= win_op;
                  id_q      <= win_idx;
                  ptr       <= nxt_ptr;
                  req_ack   <= N_REQ'(1) << win_idx;
                  sq_enable <= 1'b1;
                  state     <= StIssue;
               end
            end
            StIssue: begin
               state <= StWait;
            end
            StWait: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (sq_result) begin
                  rsp_data  <= sq_io_data;
                  rsp_nan   <= sq_is_nan;
                  rsp_pinf  <= sq_is_pinf;
                  rsp_ninf  <= sq_is_ninf;
                  rsp_id    <= id_q;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  sq_enable <= 1'b0;
                  state     <= StGap;
               end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                  rsp_data  <= 16'h7E00;
                  rsp_nan   <= 1'b1;
                  rsp_pinf  <= 1'b0;
                  rsp_ninf  <= 1'b0;
                  rsp_id    <= id_q;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  sq_enable <= 1'b0;
                  state     <= StGap;
               end
            end
            StGap: begin
               tmo_cnt <= '0;
               state   <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter with a behavioural sqrt2 unit on the shared bus.
module tb_sqrt_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [63:0] req_data = '0;
   logic [3:0]  req_ack;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        rsp_nan, rsp_pinf, rsp_ninf, rsp_err;
   logic        sq_enable;
   wire  [15:0] sq_io_data;
   logic        sq_result, sq_is_nan, sq_is_pinf, sq_is_ninf;

   sqrt_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(20)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_nan(rsp_nan), .rsp_pinf(rsp_pinf), .rsp_ninf(rsp_ninf), .rsp_err(rsp_err),
      .sq_enable(sq_enable), .sq_io_data(sq_io_data), .sq_result(sq_result),
      .sq_is_nan(sq_is_nan), .sq_is_pinf(sq_is_pinf), .sq_is_ninf(sq_is_ninf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural sqrt2: samples the operand at the edge closing ISSUE, owns the bus
   // from the next edge on, and clears whenever ENABLE is low.
   logic        stub = 1'b0;
   int          m_cnt = 0;
   logic [15:0] m_op = '0;
   logic [15:0] m_res;
   logic        m_nan, m_pinf, m_drv;
   int          m_lat;

   always @(posedge clk) begin
      if (!sq_enable) m_cnt <= 0;
      else begin
         if (m_cnt == 0) m_op <= sq_io_data;
         m_cnt <= m_cnt + 1;
      end
   end

   always_comb begin
      m_res = 16'h7E00; m_nan = 1'b1; m_pinf = 1'b0; m_lat = 2;
      case (m_op)
         16'h4400: begin m_res = 16'h4000; m_nan = 1'b0; m_lat = 12; end
         16'h4C00: begin m_res = 16'h4400; m_nan = 1'b0; m_lat = 12; end
         16'h4880: begin m_res = 16'h4200; m_nan = 1'b0; m_lat = 12; end
         16'h3C00: begin m_res = 16'h3C00; m_nan = 1'b0; m_lat = 12; end
         16'h7C00: begin m_res = 16'h7C00; m_nan = 1'b0; m_pinf = 1'b1; m_lat = 2; end
         16'hBC00: begin m_res = 16'hFE00; m_nan = 1'b1; m_lat = 12; end
         default: ;
      endcase
   end

   assign m_drv      = sq_enable && !stub && (m_cnt >= 2);
   assign sq_io_data = m_drv ? m_res : 16'bz;
   assign sq_result  = sq_enable && !stub && (m_cnt >= m_lat);
   assign sq_is_nan  = m_drv && m_nan;
   assign sq_is_pinf = m_drv && m_pinf;
   assign sq_is_ninf = 1'b0;

   typedef struct {
      int          id;
      logic [15:0] op;
      logic [15:0] data;
      logic        nan;
      logic        pinf;
      logic        err;
      int          lat;
      int          gap;
   } exp_t;

   exp_t ack_q[$];
   exp_t rsp_q[$];
   int   ack_cyc_q[$];
   int   last_ack = 0;
   logic valid_prev = 1'b0;

   task automatic expect_op(input int id, input logic [15:0] op, input logic [15:0] data,
                            input logic nan, input logic pinf, input logic err,
                            input int lat, input int gap);
      exp_t e;
      e.id = id; e.op = op; e.data = data; e.nan = nan; e.pinf = pinf; e.err = err;
      e.lat = lat; e.gap = gap;
      req_data[16*id +: 16] = op;
      ack_q.push_back(e);
   endtask

   // Monitor: grants, bus contents and responses, all sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      int   t;
      if (reset) begin
         valid_prev <= 1'b0;
      end else begin
         if (req_ack != 4'b0) begin
            if (ack_q.size() == 0) chk("unexpected_ack", 32'(req_ack), 32'h0);
            else begin
               e = ack_q.pop_front();
               chk("ack_onehot", 32'(req_ack), 32'(4'b1 << e.id));
               chk("issue_bus", 32'(sq_io_data), 32'(e.op));
               chk("issue_enable", 32'(sq_enable), 32'h1);
               if (e.gap > 0) chk("ack_spacing", cyc - last_ack, e.gap);
               last_ack = cyc;
               rsp_q.push_back(e);
               ack_cyc_q.push_back(cyc);
            end
         end
         if (m_drv) chk("bus_value", 32'(sq_io_data), 32'(m_res));
         if (rsp_valid && !valid_prev) begin
            if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            else begin
               e = rsp_q.pop_front();
               t = ack_cyc_q.pop_front();
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
               chk("rsp_id", 32'(rsp_id), e.id);
               chk("rsp_flags", 32'({rsp_nan, rsp_pinf, rsp_ninf}),
                   32'({e.nan, e.pinf, 1'b0}));
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
               chk("rsp_latency", cyc - t, e.lat);
               chk("gap_enable_low", 32'(sq_enable), 32'h0);
            end
         end
         valid_prev <= rsp_valid;
      end
   end

   int pend[4] = '{0, 0, 0, 0};

   // Holds each requester's REQ until it has received pend[i] grants.
   task automatic serve(input int budget);
      int n = 0;
      for (int i = 0; i < 4; i++) req[i] = (pend[i] > 0);
      while ((pend[0] + pend[1] + pend[2] + pend[3]) > 0 && n < budget) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < 4; i++) begin
            if (req_ack[i] && pend[i] > 0) begin
               pend[i]--;
               if (pend[i] == 0) req[i] = 1'b0;
            end
         end
      end
      chk("serve_budget", 32'(n < budget), 32'h1);
      if (n >= budget) begin
         req = '0;
         for (int i = 0; i < 4; i++) pend[i] = 0;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((ack_q.size() + rsp_q.size()) > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_budget", 32'(n < budget), 32'h1);
      ack_q.delete(); rsp_q.delete(); ack_cyc_q.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_ack(input int i, input int budget);
      int n = 0;
      while (!req_ack[i] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ack_budget", 32'(n < budget), 32'h1);
      req[i] = 1'b0;
   endtask

   initial begin
      int bad;
      int n;
      #1;
      chk("reset_ack", 32'(req_ack), 32'h0);
      chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_nan, rsp_pinf, rsp_ninf, rsp_err}),
          32'h0);
      chk("reset_enable", 32'(sq_enable), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Single normal operand from requester 0.
      expect_op(0, 16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, 13, 0);
      pend[0] = 1; serve(30); drain(40);

      // Special-value path and negative operand.
      expect_op(1, 16'h7C00, 16'h7C00, 1'b0, 1'b1, 1'b0, 3, 0);
      pend[1] = 1; serve(30); drain(40);
      expect_op(2, 16'hBC00, 16'hFE00, 1'b1, 1'b0, 1'b0, 13, 0);
      pend[2] = 1; serve(30); drain(40);

      // Unit never answers: timeout abort.
      stub = 1'b1;
      expect_op(3, 16'h4400, 16'h7E00, 1'b1, 1'b0, 1'b1, 21, 0);
      pend[3] = 1; serve(30); drain(60);
      stub = 1'b0;

      // All four requesting: round-robin order 0,1,2,3,0 at 15-cycle spacing.
      expect_op(0, 16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, 13, 0);
      expect_op(1, 16'h4C00, 16'h4400, 1'b0, 1'b0, 1'b0, 13, 15);
      expect_op(2, 16'h4880, 16'h4200, 1'b0, 1'b0, 1'b0, 13, 15);
      expect_op(3, 16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0, 13, 15);
      expect_op(0, 16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, 13, 15);
      pend = '{2, 1, 1, 1}; serve(150); drain(40);

      // Consumer stalls: no new grant, response held, grant on the cycle READY returns.
      rsp_ready = 1'b0;
      expect_op(1, 16'h4C00, 16'h4400, 1'b0, 1'b0, 1'b0, 13, 0);
      expect_op(2, 16'h4880, 16'h4200, 1'b0, 1'b0, 1'b0, 13, 0);
      req[1] = 1'b1; req[2] = 1'b1;
      wait_ack(1, 20);
      n = 0;
      while (!rsp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("stall_rsp_budget", 32'(n < 30), 32'h1);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (req_ack != 4'b0 || rsp_data != 16'h4400 || !rsp_valid) bad++;
      end
      chk("stall_hold", bad, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("regrant_ack", 32'(req_ack), 32'h4);
      req[2] = 1'b0;
      drain(40);

      // Reset in the middle of WAIT; pointer must return to requester 0.
      expect_op(0, 16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, 13, 0);
      req[0] = 1'b1;
      wait_ack(0, 20);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset_enable", 32'(sq_enable), 32'h0);
      chk("midreset_valid", 32'(rsp_valid), 32'h0);
      chk("midreset_ack", 32'(req_ack), 32'h0);
      rsp_q.delete(); ack_cyc_q.delete(); ack_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      expect_op(0, 16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0, 13, 0);
      expect_op(1, 16'h4C00, 16'h4400, 1'b0, 1'b0, 1'b0, 13, 15);
      pend[0] = 1; pend[1] = 1; serve(60); drain(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
